multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Main control unit for the RV32I multicycle core. A Moore-style state machine sequences fetch, decode, execute, memory and writeback for each instruction. It drives every datapath select and write enable, including result_src (ResultSource_t). Shared instruction/data memory is accessed through a req/ready handshake, so every memory state can stall.

Parameters:
None. Widths are fixed by RV32I.

Ports:
clk  in  1  core clock, all state changes on rising edge
rst_n  in  1  synchronous reset, active-low
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
zero  in  1  ALU zero flag, combinational from current ALU result
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_write  out  1  access is a store; valid only with mem_req
adr_src  out  1  0 = PC, 1 = ALUOut drives memory address
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  register file write enable
result_src  out  2  ResultSource_t: ALU = ALUOut reg, MEM = data reg, PC4 = direct ALU result
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 reg
alu_src_b  out  2  00 rs2 reg, 01 immediate, 10 constant 4
alu_op  out  2  00 add, 01 sub, 10 decode funct fields
imm_src  out  2  00 I, 01 S, 10 B, 11 J
illegal_instr  out  1  one-cycle pulse on unsupported instruction

Behaviour:
- Reset (sync): rst_n=0 at the clock edge loads the state register with FETCH. While rst_n=0, the following are forced to 0 combinationally: mem_req, mem_write, ir_write, pc_write, reg_write and illegal_instr. Select outputs take their FETCH values. Reset mid-access abandons the access; memory sees mem_req drop.
- Outputs are a function of state only, except for three signals:
  - pc_write and ir_write in FETCH are gated by mem_ready.
  - pc_write in BRANCH is gated by the branch condition.
  - imm_src and illegal_instr in DECODE are gated by opcode/funct3.
- Unlisted outputs are 0.
- FETCH: mem_req=1, adr_src=0, a=PC, b=4, alu_op=add, result_src=PC4. On mem_ready: ir_write=1, pc_write=1, next state DECODE. Otherwise hold in FETCH.
- DECODE: a=OldPC, b=imm, alu_op=add (precomputes target). imm_src follows opcode: S for stores, B for branches, J for jal, I otherwise. Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 with funct3 ∈ {000, 001} → BRANCH
  - anything else → FETCH, with illegal_instr=1 for this cycle; no architectural write occurs.
- MEMADR: a=rs1, b=imm, alu_op=add. Next state MEMREAD if opcode is a load, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=ALU. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=MEM, reg_write=1. Next state FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=ALU. Hold until mem_ready, then FETCH.
- EXECR: a=rs1, b=rs2, alu_op=funct. Next state ALUWB.
- EXECI: a=rs1, b=imm, alu_op=funct. Next state ALUWB.
- ALUWB: result_src=ALU, reg_write=1. Next state FETCH.
- JAL: a=OldPC, b=4, alu_op=add, result_src=ALU (target), pc_write=1. Next state ALUWB, which writes OldPC+4 to rd.
- BRANCH: a=rs1, b=rs2, alu_op=sub, result_src=ALU. pc_write = zero XOR funct3[0], so beq takes on equal and bne on not-equal. Next state FETCH.
- Latency with zero wait states: load 5 cycles; store, R-type, I-type and jal 4 cycles; branch 3 cycles. Each memory stall adds one cycle per mem_ready=0 cycle.
- mem_req stays asserted, with stable adr_src and mem_write, until the mem_ready cycle. It drops the cycle after.
- The state encoding is one enum. Any unreachable encoding returns to FETCH.

Decomposition:
- multicycle_ctrl_pkg holds:
  - state enum CtrlState_t;
  - AluSrcA_t, AluSrcB_t, AluOp_t and ImmSrc_t enums;
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL and OP_BRANCH.
- result_src uses ResultSource_t from ResultSource_pkg.
- One sub-module, instr_class_decoder, is combinational. It maps opcode/funct3 to an instruction class plus an illegal flag, and is used by DECODE and MEMADR.

Test Plan:
- Reset then lw, mem_ready=1 always: state trace FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. reg_write=1 only in cycle 5, with result_src=MEM. ir_write=1 only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWRITE: mem_req=1 and mem_write=1 for 4 cycles with adr_src=1 throughout, then FETCH. reg_write is never asserted.
- add (0110011) then addi (0010011): each takes 4 cycles; alu_op=10 in EXEC, reg_write in ALUWB with result_src=ALU.
- beq with zero=1 → pc_write=1 in BRANCH; beq with zero=0 → pc_write=0; bne (funct3=001) with zero=0 → pc_write=1. Each takes 3 cycles.
- jal: pc_write=1 in JAL with b=4 and a=OldPC, then ALUWB with reg_write=1; 4 cycles total.
- opcode 0110111 (unsupported) → illegal_instr pulses for 1 cycle in DECODE and the next state is FETCH with no writes. rst_n=0 asserted during a MEMREAD stall → next state FETCH and mem_req=0 while reset is held.

Source files
------------

// File: rtl/ResultSource_pkg.sv
// Result bus source select shared by the control unit and the datapath mux.
package ResultSource_pkg;

    // ALU = registered ALUOut, MEM = data register, PC4 = live ALU result
    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } ResultSource_t;

endpackage

// File: rtl/multicycle_ctrl_pkg.sv
// Types and opcode constants for the RV32I multicycle control unit.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } CtrlState_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } AluSrcA_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } AluSrcB_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } AluOp_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } ImmSrc_t;

    // Coarse instruction class seen by the sequencer
    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_ITYPE  = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_NONE   = 3'd6
    } InstrClass_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational opcode/funct3 classifier; anything unsupported is CLS_NONE + illegal.
module instr_class_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output InstrClass_t instr_class,
    output logic        illegal
);

    // Only beq (000) and bne (001) are supported among branches
    always_comb begin
        instr_class = CLS_NONE;
        case (opcode)
            OP_LOAD:   instr_class = CLS_LOAD;
            OP_STORE:  instr_class = CLS_STORE;
            OP_RTYPE:  instr_class = CLS_RTYPE;
            OP_ITYPE:  instr_class = CLS_ITYPE;
            OP_JAL:    instr_class = CLS_JAL;
            OP_BRANCH: instr_class = (funct3[2:1] == 2'b00) ? CLS_BRANCH : CLS_NONE;
            default:   instr_class = CLS_NONE;
        endcase
        illegal = (instr_class == CLS_NONE);
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore-style main control FSM for the RV32I multicycle core.
// Memory handshake: mem_req is held with stable adr_src/mem_write until the
// cycle mem_ready is high; that cycle completes the access and the FSM moves on.
module multicycle_control_fsm
    import multicycle_ctrl_pkg::*;
    import ResultSource_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic          zero,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic          mem_write,
    output logic          adr_src,
    output logic          ir_write,
    output logic          pc_write,
    output logic          reg_write,
    output ResultSource_t result_src,
    output logic [1:0]    alu_src_a,
    output logic [1:0]    alu_src_b,
    output logic [1:0]    alu_op,
    output logic [1:0]    imm_src,
    output logic          illegal_instr
);

    CtrlState_t  state_q, state_d;
    InstrClass_t instr_class;
    logic        dec_illegal;
    AluSrcA_t    src_a;
    AluSrcB_t    src_b;
    AluOp_t      op_sel;
    ImmSrc_t     imm_sel;

    instr_class_decoder u_instr_class_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .instr_class (instr_class),
        .illegal     (dec_illegal)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and output decode; reset forces enables low and FETCH selects
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = RESULT_ALU;
        src_a         = SRCA_PC;
        src_b         = SRCB_RS2;
        op_sel        = ALUOP_ADD;
        imm_sel       = IMM_I;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RESULT_PC4;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (opcode)
                    OP_STORE:  imm_sel = IMM_S;
                    OP_BRANCH: imm_sel = IMM_B;
                    OP_JAL:    imm_sel = IMM_J;
                    default:   imm_sel = IMM_I;
                endcase
                illegal_instr = dec_illegal;
                case (instr_class)
                    CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
                    CLS_RTYPE:           state_d = S_EXECR;
                    CLS_ITYPE:           state_d = S_EXECI;
                    CLS_JAL:             state_d = S_JAL;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = (instr_class == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RESULT_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                op_sel  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                op_sel  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BRANCH: begin
                src_a    = SRCA_RS1;
                src_b    = SRCB_RS2;
                op_sel   = ALUOP_SUB;
                // beq takes on zero, bne on not-zero
                pc_write = zero ^ funct3[0];
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
            result_src    = RESULT_PC4;
            src_a         = SRCA_PC;
            src_b         = SRCB_FOUR;
            op_sel        = ALUOP_ADD;
            imm_sel       = IMM_I;
            state_d       = S_FETCH;
        end
    end

    assign alu_src_a = src_a;
    assign alu_src_b = src_b;
    assign alu_op    = op_sel;
    assign imm_src   = imm_sel;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-accurate bench for multicycle_control_fsm: expected output vectors
// are queued as each cycle's inputs are driven and compared at the falling edge.
module tb_multicycle_control_fsm;
    import multicycle_ctrl_pkg::*;
    import ResultSource_pkg::*;

    localparam int W = 21;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       illegal_instr;

    logic [W-1:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    multicycle_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    // Clock
    always #5 clk = ~clk;

    // Vector: {state, req, wr, adr, irw, pcw, rw, rs, a, b, op, imm, ill}
    function automatic logic [W-1:0] mk(input logic [3:0] st, input logic req, input logic wr,
                                        input logic adr, input logic irw, input logic pcw,
                                        input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] op,
                                        input logic [1:0] imm, input logic ill);
        return {st, req, wr, adr, irw, pcw, rw, rs, a, b, op, imm, ill};
    endfunction

    function automatic logic [W-1:0] observed();
        logic [3:0] st;
        st = dut.state_q;
        return {st, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr};
    endfunction

    // Expected per-state vectors
    function automatic logic [W-1:0] v_fetch(input logic rdy);
        return mk(S_FETCH, 1, 0, 0, rdy, rdy, 0, RESULT_PC4, SRCA_PC, SRCB_FOUR, ALUOP_ADD, IMM_I, 0);
    endfunction
    function automatic logic [W-1:0] v_decode(input logic [1:0] imm, input logic ill);
        return mk(S_DECODE, 0, 0, 0, 0, 0, 0, RESULT_ALU, SRCA_OLDPC, SRCB_IMM, ALUOP_ADD, imm, ill);
    endfunction
    function automatic logic [W-1:0] v_memadr();
        return mk(S_MEMADR, 0, 0, 0, 0, 0, 0, RESULT_ALU, SRCA_RS1, SRCB_IMM, ALUOP_ADD, IMM_I, 0);
    endfunction
    function automatic logic [W-1:0] v_memread();
        return mk(S_MEMREAD, 1, 0, 1, 0, 0, 0, RESULT_ALU, SRCA_PC, SRCB_RS2, ALUOP_ADD, IMM_I, 0);
    endfunction
    function automatic logic [W-1:0] v_memwrite();
        return mk(S_MEMWRITE, 1, 1, 1, 0, 0, 0, RESULT_ALU, SRCA_PC, SRCB_RS2, ALUOP_ADD, IMM_I, 0);
    endfunction
    function automatic logic [W-1:0] v_memwb();
        return mk(S_MEMWB, 0, 0, 0, 0, 0, 1, RESULT_MEM, SRCA_PC, SRCB_RS2, ALUOP_ADD, IMM_I, 0);
    endfunction
    function automatic logic [W-1:0] v_aluwb();
        return mk(S_ALUWB, 0, 0, 0, 0, 0, 1, RESULT_ALU, SRCA_PC, SRCB_RS2, ALUOP_ADD, IMM_I, 0);
    endfunction

    // Scoreboard check
    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare at the falling edge
    task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic rdy, input logic [W-1:0] exp, input string tag);
        rst_n = rst; opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
        exp_q.push_back(exp);
        @(negedge clk);
        check_eq(tag, observed(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [6:0] op, input logic [2:0] f3, input int stalls, input string tag);
        for (int i = 0; i < stalls; i++) step(1, op, f3, 0, 0, v_fetch(0), {tag, "_fetch_stall"});
        step(1, op, f3, 0, 1, v_fetch(1), {tag, "_fetch"});
    endtask

    task automatic do_lw(input int fstalls, input int rstalls);
        do_fetch(OP_LOAD, 3'b010, fstalls, "lw");
        step(1, OP_LOAD, 3'b010, 0, 0, v_decode(IMM_I, 0), "lw_decode");
        step(1, OP_LOAD, 3'b010, 0, 0, v_memadr(), "lw_memadr");
        for (int i = 0; i < rstalls; i++) step(1, OP_LOAD, 3'b010, 0, 0, v_memread(), "lw_memread_stall");
        step(1, OP_LOAD, 3'b010, 0, 1, v_memread(), "lw_memread");
        step(1, OP_LOAD, 3'b010, 0, 0, v_memwb(), "lw_memwb");
    endtask

    task automatic do_sw(input int wstalls);
        do_fetch(OP_STORE, 3'b010, 0, "sw");
        step(1, OP_STORE, 3'b010, 0, 0, v_decode(IMM_S, 0), "sw_decode");
        step(1, OP_STORE, 3'b010, 0, 0, v_memadr(), "sw_memadr");
        for (int i = 0; i < wstalls; i++) step(1, OP_STORE, 3'b010, 0, 0, v_memwrite(), "sw_memwrite_stall");
        step(1, OP_STORE, 3'b010, 0, 1, v_memwrite(), "sw_memwrite");
    endtask

    task automatic do_alu(input logic is_imm);
        logic [6:0] op;
        op = is_imm ? OP_ITYPE : OP_RTYPE;
        do_fetch(op, 3'b000, 0, "alu");
        step(1, op, 3'b000, 0, 0, v_decode(IMM_I, 0), "alu_decode");
        if (is_imm)
            step(1, op, 3'b000, 0, 0, mk(S_EXECI, 0, 0, 0, 0, 0, 0, RESULT_ALU, SRCA_RS1, SRCB_IMM, ALUOP_FUNCT, IMM_I, 0), "addi_execi");
        else
            step(1, op, 3'b000, 0, 0, mk(S_EXECR, 0, 0, 0, 0, 0, 0, RESULT_ALU, SRCA_RS1, SRCB_RS2, ALUOP_FUNCT, IMM_I, 0), "add_execr");
        step(1, op, 3'b000, 0, 0, v_aluwb(), "alu_aluwb");
    endtask

    task automatic do_branch(input logic [2:0] f3, input logic z, input logic take);
        do_fetch(OP_BRANCH, f3, 0, "br");
        step(1, OP_BRANCH, f3, z, 0, v_decode(IMM_B, 0), "br_decode");
        step(1, OP_BRANCH, f3, z, 0, mk(S_BRANCH, 0, 0, 0, 0, take, 0, RESULT_ALU, SRCA_RS1, SRCB_RS2, ALUOP_SUB, IMM_I, 0), "br_branch");
    endtask

    task automatic do_jal();
        do_fetch(OP_JAL, 3'b000, 0, "jal");
        step(1, OP_JAL, 3'b000, 0, 0, v_decode(IMM_J, 0), "jal_decode");
        step(1, OP_JAL, 3'b000, 0, 0, mk(S_JAL, 0, 0, 0, 0, 1, 0, RESULT_ALU, SRCA_OLDPC, SRCB_FOUR, ALUOP_ADD, IMM_I, 0), "jal_jal");
        step(1, OP_JAL, 3'b000, 0, 0, v_aluwb(), "jal_aluwb");
    endtask

    task automatic do_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] imm);
        do_fetch(op, f3, 0, "ill");
        step(1, op, f3, 0, 0, v_decode(imm, 1), "ill_decode");
    endtask

    // Reset vector: state as given, enables low, FETCH selects
    function automatic logic [W-1:0] v_reset(input logic [3:0] st);
        return mk(st, 0, 0, 0, 0, 0, 0, RESULT_PC4, SRCA_PC, SRCB_FOUR, ALUOP_ADD, IMM_I, 0);
    endfunction

    // Stimulus sequence and final report
    initial begin
        rst_n = 0; opcode = '0; funct3 = '0; zero = 0; mem_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        step(0, OP_LOAD, 3'b010, 0, 1, v_reset(S_FETCH), "reset_hold");

        do_lw(0, 0);
        do_sw(3);
        do_alu(0);
        do_alu(1);
        do_branch(3'b000, 1, 1);
        do_branch(3'b000, 0, 0);
        do_branch(3'b001, 0, 1);
        do_branch(3'b001, 1, 0);
        do_jal();
        do_illegal(7'b0110111, 3'b000, IMM_I);
        do_illegal(OP_BRANCH, 3'b010, IMM_B);

        for (int n = 0; n < 4; n++) do_lw($urandom_range(0, 2), $urandom_range(0, 3));

        // Reset during a MEMREAD stall
        do_fetch(OP_LOAD, 3'b010, 0, "rst");
        step(1, OP_LOAD, 3'b010, 0, 0, v_decode(IMM_I, 0), "rst_decode");
        step(1, OP_LOAD, 3'b010, 0, 0, v_memadr(), "rst_memadr");
        step(1, OP_LOAD, 3'b010, 0, 0, v_memread(), "rst_memread_stall");
        step(0, OP_LOAD, 3'b010, 0, 0, v_reset(S_MEMREAD), "rst_in_memread");
        step(0, OP_LOAD, 3'b010, 0, 1, v_reset(S_FETCH), "rst_held_fetch");
        do_alu(0);
        step(1, OP_RTYPE, 3'b000, 0, 1, v_fetch(1), "final_fetch");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
